// File: rtl/glyph_scan_ctrl.sv
// Scan sequencer for a 16x16 glyph ROM driving a multiplexed LED matrix:
// serialises each row into a column shift/latch driver, then lights that row.
module glyph_scan_ctrl #(
  parameter int DWELL       = 1000,
  parameter int HOLD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        auto,
  input  logic [1:0]  sel_in,
  input  logic        pixel,
  output logic [3:0]  row,
  output logic [3:0]  col,
  output logic [1:0]  select,
  output logic        led_sdi,
  output logic        led_sclk,
  output logic        led_latch,
  output logic [15:0] row_en,
  output logic        frame_done,
  output logic        busy
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

  state_t        state, state_d;
  logic          phase, phase_d;
  logic [DW-1:0] dcnt, dcnt_d;
  logic [HW-1:0] fcnt, fcnt_d;
  logic [3:0]    row_d, col_d;
  logic [1:0]    select_d;
  logic          sdi_d, sclk_d, latch_d, fd_d, busy_d;
  logic [15:0]   row_en_d;

  always_comb begin
    state_d  = state;
    phase_d  = phase;
    dcnt_d   = dcnt;
    fcnt_d   = fcnt;
    row_d    = row;
    col_d    = col;
    select_d = select;
    sdi_d    = led_sdi;
    sclk_d   = led_sclk;
    latch_d  = 1'b0;
    fd_d     = 1'b0;
    row_en_d = row_en;

    case (state)
      IDLE: begin
        sclk_d   = 1'b0;
        row_en_d = '0;
        if (enable) begin
          state_d  = SHIFT;
          phase_d  = 1'b0;
          row_d    = '0;
          col_d    = '0;
          select_d = auto ? 2'd1 : sel_in;
          fcnt_d   = '0;
        end
      end
      SHIFT: begin
        if (!phase) begin
          // ROM answers combinationally, so capture it as sclk rises
          sdi_d   = pixel;
          sclk_d  = 1'b1;
          phase_d = 1'b1;
        end else begin
          sclk_d  = 1'b0;
          phase_d = 1'b0;
          if (col == 4'd15) begin
            col_d   = '0;
            state_d = LATCH;
            latch_d = 1'b1;
          end else begin
            col_d = col + 4'd1;
          end
        end
      end
      LATCH: begin
        row_en_d = 16'd1 << row;
        state_d  = DISPLAY;
        dcnt_d   = '0;
      end
      DISPLAY: begin
        if (dcnt == DW'(DWELL - 1)) begin
          row_en_d = '0;
          state_d  = SHIFT;
          phase_d  = 1'b0;
          if (row == 4'd15) begin
            row_d = '0;
            fd_d  = 1'b1;
            // glyph choice only moves on frame boundaries
            if (auto) begin
              if (fcnt == HW'(HOLD_FRAMES - 1)) begin
                select_d = (select == 2'd1) ? 2'd2 : 2'd1;
                fcnt_d   = '0;
              end else begin
                fcnt_d = fcnt + HW'(1);
              end
            end else begin
              select_d = sel_in;
              fcnt_d   = '0;
            end
          end else begin
            row_d = row + 4'd1;
          end
        end else begin
          dcnt_d = dcnt + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // dropping enable blanks everything next edge but keeps the glyph choice
    if (!enable) begin
      state_d  = IDLE;
      phase_d  = 1'b0;
      dcnt_d   = '0;
      row_d    = '0;
      col_d    = '0;
      sdi_d    = 1'b0;
      sclk_d   = 1'b0;
      latch_d  = 1'b0;
      fd_d     = 1'b0;
      row_en_d = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= 1'b0;
      dcnt       <= '0;
      fcnt       <= '0;
      row        <= '0;
      col        <= '0;
      select     <= '0;
      led_sdi    <= 1'b0;
      led_sclk   <= 1'b0;
      led_latch  <= 1'b0;
      row_en     <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      phase      <= phase_d;
      dcnt       <= dcnt_d;
      fcnt       <= fcnt_d;
      row        <= row_d;
      col        <= col_d;
      select     <= select_d;
      led_sdi    <= sdi_d;
      led_sclk   <= sclk_d;
      led_latch  <= latch_d;
      row_en     <= row_en_d;
      frame_done <= fd_d;
      busy       <= busy_d;
    end
  end

endmodule
